// File: rtl/time_set_ctrl.sv
// Mode/setting controller for the sec/min/hour BCD clock chain.
// Edits a shadow time in SET states and presets the counters on exit.
module time_set_ctrl #(
  parameter int BLINK_HALF  = 500,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic       run_en,
  output logic [7:0] pre_hour,
  output logic [7:0] pre_min,
  output logic [7:0] pre_sec,
  output logic       PE_hour,
  output logic       PE_min,
  output logic       PE_sec,
  output logic [1:0] mode,
  output logic [2:0] blink,
  output logic [7:0] disp_hour,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic mode_s1_q, mode_s2_q, mode_prev_q;
  logic inc_s1_q, inc_s2_q, inc_prev_q;
  logic mode_edge, inc_edge;

  logic [7:0] sh_hour_q, sh_hour_d;
  logic [7:0] sh_min_q, sh_min_d;
  logic [7:0] sh_sec_q, sh_sec_d;
  logic [7:0] pre_hour_q, pre_hour_d;
  logic [7:0] pre_min_q, pre_min_d;
  logic [7:0] pre_sec_q, pre_sec_d;
  logic       pe_q, pe_d;
  logic       run_en_q, run_en_d;

  logic [TW-1:0] to_q, to_d;
  logic          to_hit;

  logic [BW-1:0] bl_q, bl_d;
  logic          ph_q, ph_d;
  logic          chg;

  // BCD increment with wrap at max; malformed values restart at 00
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    logic [7:0] r;
    if (v[3:0] > 4'd9 || v >= max)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Two-flop synchronisers plus previous-level flops for edge detect
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      mode_s1_q   <= 1'b0;
      mode_s2_q   <= 1'b0;
      mode_prev_q <= 1'b0;
      inc_s1_q    <= 1'b0;
      inc_s2_q    <= 1'b0;
      inc_prev_q  <= 1'b0;
    end else begin
      mode_s1_q   <= btn_mode;
      mode_s2_q   <= mode_s1_q;
      mode_prev_q <= mode_s2_q;
      inc_s1_q    <= btn_inc;
      inc_s2_q    <= inc_s1_q;
      inc_prev_q  <= inc_s2_q;
    end
  end

  assign mode_edge = mode_s2_q & ~mode_prev_q;
  assign inc_edge  = inc_s2_q & ~inc_prev_q;
  assign to_hit    = (to_q == TW'(TIMEOUT_CYC - 1));

  // Mode sequencing, shadow editing, preset loading and idle timeout
  always_comb begin
    state_d    = state_q;
    sh_hour_d  = sh_hour_q;
    sh_min_d   = sh_min_q;
    sh_sec_d   = sh_sec_q;
    pre_hour_d = pre_hour_q;
    pre_min_d  = pre_min_q;
    pre_sec_d  = pre_sec_q;
    pe_d       = 1'b0;
    to_d       = '0;
    unique case (state_q)
      RUN: begin
        if (mode_edge) begin
          state_d   = SET_HOUR;
          sh_hour_d = cur_hour;
          sh_min_d  = cur_min;
          sh_sec_d  = cur_sec;
        end
      end
      SET_HOUR: begin
        if (mode_edge)
          state_d = SET_MIN;
        else if (inc_edge)
          sh_hour_d = bcd_inc(sh_hour_q, 8'h23);
        else if (to_hit)
          state_d = RUN;
        else
          to_d = to_q + TW'(1);
      end
      SET_MIN: begin
        if (mode_edge)
          state_d = SET_SEC;
        else if (inc_edge)
          sh_min_d = bcd_inc(sh_min_q, 8'h59);
        else if (to_hit)
          state_d = RUN;
        else
          to_d = to_q + TW'(1);
      end
      SET_SEC: begin
        if (mode_edge) begin
          state_d    = RUN;
          pre_hour_d = sh_hour_q;
          pre_min_d  = sh_min_q;
          pre_sec_d  = sh_sec_q;
          pe_d       = 1'b1;
        end else if (inc_edge)
          sh_sec_d = bcd_inc(sh_sec_q, 8'h59);
        else if (to_hit)
          state_d = RUN;
        else
          to_d = to_q + TW'(1);
      end
    endcase
    run_en_d = (state_q == RUN) && (state_d == RUN);
  end

  // Blink phase restarts visible whenever the edited view changes
  always_comb begin
    chg  = (state_d != state_q) ||
           ({sh_hour_d, sh_min_d, sh_sec_d} !=
            {sh_hour_q, sh_min_q, sh_sec_q});
    bl_d = bl_q + BW'(1);
    ph_d = ph_q;
    if (chg) begin
      bl_d = '0;
      ph_d = 1'b0;
    end else if (bl_q == BW'(BLINK_HALF - 1)) begin
      bl_d = '0;
      ph_d = ~ph_q;
    end
  end

  // Controller state registers
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      state_q    <= RUN;
      sh_hour_q  <= 8'h00;
      sh_min_q   <= 8'h00;
      sh_sec_q   <= 8'h00;
      pre_hour_q <= 8'h00;
      pre_min_q  <= 8'h00;
      pre_sec_q  <= 8'h00;
      pe_q       <= 1'b0;
      run_en_q   <= 1'b1;
      to_q       <= '0;
      bl_q       <= '0;
      ph_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_hour_q  <= sh_hour_d;
      sh_min_q   <= sh_min_d;
      sh_sec_q   <= sh_sec_d;
      pre_hour_q <= pre_hour_d;
      pre_min_q  <= pre_min_d;
      pre_sec_q  <= pre_sec_d;
      pe_q       <= pe_d;
      run_en_q   <= run_en_d;
      to_q       <= to_d;
      bl_q       <= bl_d;
      ph_q       <= ph_d;
    end
  end

  // Display source and blink field selection follow the mode
  always_comb begin
    blink     = 3'b000;
    disp_hour = sh_hour_q;
    disp_min  = sh_min_q;
    disp_sec  = sh_sec_q;
    unique case (state_q)
      RUN: begin
        disp_hour = cur_hour;
        disp_min  = cur_min;
        disp_sec  = cur_sec;
      end
      SET_HOUR: blink = {ph_q, 2'b00};
      SET_MIN:  blink = {1'b0, ph_q, 1'b0};
      SET_SEC:  blink = {2'b00, ph_q};
    endcase
  end

  assign mode     = state_q;
  assign run_en   = run_en_q;
  assign pre_hour = pre_hour_q;
  assign pre_min  = pre_min_q;
  assign pre_sec  = pre_sec_q;
  assign PE_hour  = pe_q;
  assign PE_min   = pe_q;
  assign PE_sec   = pe_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl.
// Stimulus queues expected snapshots and presets; a monitor checks them.
module tb_time_set_ctrl;

  localparam int BH = 500;
  localparam int TO = 10000;

  logic       clk = 1'b0;
  logic       CR;
  logic       btn_mode, btn_inc;
  logic [7:0] cur_hour, cur_min, cur_sec;
  logic       run_en;
  logic [7:0] pre_hour, pre_min, pre_sec;
  logic       PE_hour, PE_min, PE_sec;
  logic [1:0] mode;
  logic [2:0] blink;
  logic [7:0] disp_hour, disp_min, disp_sec;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  mode;
    logic        run;
    logic [23:0] pre;
    logic [23:0] disp;
    logic [2:0]  blink;
    logic        cb;
  } snap_t;

  snap_t       exp_q[$];
  logic [23:0] pe_q[$];

  time_set_ctrl #(.BLINK_HALF(BH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .CR(CR),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .run_en(run_en),
    .pre_hour(pre_hour), .pre_min(pre_min), .pre_sec(pre_sec),
    .PE_hour(PE_hour), .PE_min(PE_min), .PE_sec(PE_sec),
    .mode(mode), .blink(blink),
    .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec)
  );

  always #5 clk = ~clk;

  // Monitor: preset strobes and queued snapshots, sampled mid-cycle
  snap_t       s;
  logic [23:0] p;
  always @(negedge clk) begin
    if (PE_hour | PE_min | PE_sec) begin
      n_chk++;
      if (pe_q.size() == 0) begin
        n_fail++;
        $display("FAIL pe_unexpected got PE=%b%b%b pre=%h%h%h",
                 PE_hour, PE_min, PE_sec, pre_hour, pre_min, pre_sec);
      end else begin
        p = pe_q.pop_front();
        if (!(PE_hour && PE_min && PE_sec) ||
            {pre_hour, pre_min, pre_sec} !== p || run_en !== 1'b0) begin
          n_fail++;
          $display("FAIL pe_load got PE=%b%b%b pre=%h%h%h run=%b want 111 pre=%h run=0",
                   PE_hour, PE_min, PE_sec, pre_hour, pre_min, pre_sec,
                   run_en, p);
        end
      end
    end
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      n_chk++;
      if (mode !== s.mode) begin
        n_fail++;
        $display("FAIL mode got %0d want %0d", mode, s.mode);
      end
      n_chk++;
      if (run_en !== s.run) begin
        n_fail++;
        $display("FAIL run_en got %b want %b", run_en, s.run);
      end
      n_chk++;
      if ({pre_hour, pre_min, pre_sec} !== s.pre) begin
        n_fail++;
        $display("FAIL pre got %h%h%h want %h",
                 pre_hour, pre_min, pre_sec, s.pre);
      end
      n_chk++;
      if ({disp_hour, disp_min, disp_sec} !== s.disp) begin
        n_fail++;
        $display("FAIL disp got %h%h%h want %h",
                 disp_hour, disp_min, disp_sec, s.disp);
      end
      if (s.cb) begin
        n_chk++;
        if (blink !== s.blink) begin
          n_fail++;
          $display("FAIL blink got %b want %b", blink, s.blink);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the button(s) through the 3rd rising edge, then release
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc(3);
  endtask

  task automatic chk(input logic [1:0] md, input logic rn,
                     input logic [23:0] pr, input logic [23:0] dp,
                     input logic [2:0] bl, input logic cb);
    snap_t e;
    e.mode = md; e.run = rn; e.pre = pr;
    e.disp = dp; e.blink = bl; e.cb = cb;
    exp_q.push_back(e);
    cyc(2);
  endtask

  task automatic set_cur(input logic [23:0] t);
    {cur_hour, cur_min, cur_sec} = t;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    CR = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    set_cur(24'h123456);
    cyc(3);
    CR = 1'b0;
    cyc(2);
    chk(2'd0, 1'b1, 24'h000000, 24'h123456, 3'b000, 1'b1);

    // enter SET_HOUR, watch blink phase
    press(1'b1, 1'b0);
    chk(2'd1, 1'b0, 24'h000000, 24'h123456, 3'b000, 1'b0);
    cyc(510);
    chk(2'd1, 1'b0, 24'h000000, 24'h123456, 3'b100, 1'b1);
    cyc(500);
    chk(2'd1, 1'b0, 24'h000000, 24'h123456, 3'b000, 1'b1);

    press(1'b0, 1'b1);
    chk(2'd1, 1'b0, 24'h000000, 24'h133456, 3'b000, 1'b0);
    press(1'b1, 1'b1);
    chk(2'd2, 1'b0, 24'h000000, 24'h133456, 3'b000, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd2, 1'b0, 24'h000000, 24'h133556, 3'b000, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd3, 1'b0, 24'h000000, 24'h133557, 3'b000, 1'b0);
    pe_q.push_back(24'h133557);
    press(1'b1, 1'b0);
    chk(2'd0, 1'b1, 24'h133557, 24'h123456, 3'b000, 1'b1);

    // wrap boundaries
    set_cur(24'h235909);
    press(1'b1, 1'b0);
    chk(2'd1, 1'b0, 24'h133557, 24'h235909, 3'b000, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd1, 1'b0, 24'h133557, 24'h005909, 3'b000, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd2, 1'b0, 24'h133557, 24'h000009, 3'b000, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd3, 1'b0, 24'h133557, 24'h000010, 3'b000, 1'b0);
    pe_q.push_back(24'h000010);
    press(1'b1, 1'b0);
    chk(2'd0, 1'b1, 24'h000010, 24'h235909, 3'b000, 1'b1);

    // full edit to 07:08:09
    set_cur(24'h060708);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd1, 1'b0, 24'h000010, 24'h070708, 3'b000, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd2, 1'b0, 24'h000010, 24'h070808, 3'b000, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd3, 1'b0, 24'h000010, 24'h070809, 3'b000, 1'b0);
    pe_q.push_back(24'h070809);
    press(1'b1, 1'b0);
    chk(2'd0, 1'b1, 24'h070809, 24'h060708, 3'b000, 1'b1);

    // inc in RUN has no effect
    press(1'b0, 1'b1);
    chk(2'd0, 1'b1, 24'h070809, 24'h060708, 3'b000, 1'b1);

    // 09 -> 10, then reset mid-edit
    set_cur(24'h090000);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd1, 1'b0, 24'h070809, 24'h100000, 3'b000, 1'b0);
    @(negedge clk);
    CR = 1'b1;
    #1;
    chk(2'd0, 1'b1, 24'h000000, 24'h090000, 3'b000, 1'b1);
    CR = 1'b0;
    cyc(2);

    // malformed fields, then idle timeout in SET_MIN
    set_cur(24'h1A6530);
    press(1'b1, 1'b0);
    chk(2'd1, 1'b0, 24'h000000, 24'h1A6530, 3'b000, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd1, 1'b0, 24'h000000, 24'h006530, 3'b000, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk(2'd2, 1'b0, 24'h000000, 24'h000030, 3'b000, 1'b0);
    n = 0;
    while (mode != 2'd0 && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n != TO - 5) begin
      n_fail++;
      $display("FAIL timeout_cycles got %0d want %0d", n, TO - 5);
    end
    cyc(2);
    chk(2'd0, 1'b1, 24'h000000, 24'h1A6530, 3'b000, 1'b1);

    cyc(5);
    n_chk++;
    if (exp_q.size() != 0 || pe_q.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained got snap=%0d pe=%0d want 0 0",
               exp_q.size(), pe_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
